// File: rtl/lifirx_pkg.sv
// Shared constants and state encodings for the LiFi receive frame buffer.
package lifirx_pkg;

    localparam int unsigned ADDR_CTRL      = 32'h0000_0000;
    localparam int unsigned ADDR_STATUS    = 32'h0000_0004;
    localparam int unsigned ADDR_FRMCNT    = 32'h0000_0008;
    localparam int unsigned ADDR_ACK       = 32'h0000_000C;
    localparam int unsigned ADDR_DATA_BASE = 32'h0000_0100;

    typedef enum logic [1:0] {
        WRIDLE = 2'd0,
        WRDATA = 2'd1,
        WRRESP = 2'd2
    } wr_state_e;

    typedef enum logic {
        RDIDLE = 1'b0,
        RDDATA = 1'b1
    } rd_state_e;

    typedef enum logic [1:0] {
        S_IDLE    = 2'd0,
        S_CAPTURE = 2'd1,
        S_DONE    = 2'd2
    } strm_state_e;

    typedef enum logic [1:0] {
        DEMOD_BPSK  = 2'd0,
        DEMOD_QPSK  = 2'd1,
        DEMOD_QAM16 = 2'd2
    } demod_e;

    // Forward FFT, fixed for the receive path.
    localparam logic [7:0] FFT_CONFIG = 8'h01;

endpackage

// File: rtl/lifirx_axil_slave.sv
// AXI4-Lite slave handshake FSMs; presents a simple write/read strobe interface
// to the register bank. Write and read channels run independently.
module lifirx_axil_slave
    import lifirx_pkg::*;
#(
    parameter int ADDR_BITS = 9
) (
    input  logic                 aclk,
    input  logic                 aresetn,
    input  logic [31:0]          s_axi_awaddr,
    input  logic                 s_axi_awvalid,
    output logic                 s_axi_awready,
    input  logic [31:0]          s_axi_wdata,
    input  logic [3:0]           s_axi_wstrb,
    input  logic                 s_axi_wvalid,
    output logic                 s_axi_wready,
    output logic [1:0]           s_axi_bresp,
    output logic                 s_axi_bvalid,
    input  logic                 s_axi_bready,
    input  logic [31:0]          s_axi_araddr,
    input  logic                 s_axi_arvalid,
    output logic                 s_axi_arready,
    output logic [31:0]          s_axi_rdata,
    output logic [1:0]           s_axi_rresp,
    output logic                 s_axi_rvalid,
    input  logic                 s_axi_rready,
    output logic                 wr_en,
    output logic [ADDR_BITS-1:0] wr_addr,
    output logic [31:0]          wr_data,
    output logic [3:0]           wr_mask,
    output logic                 rd_en,
    output logic [ADDR_BITS-1:0] rd_addr,
    input  logic [31:0]          rd_data
);

    wr_state_e            wstate_r;
    rd_state_e            rstate_r;
    logic                 awready_r;
    logic                 wready_r;
    logic                 bvalid_r;
    logic [ADDR_BITS-1:0] waddr_r;
    logic                 arready_r;
    logic                 rvalid_r;
    logic [31:0]          rdata_r;
    logic                 unused_addr_s;

    assign unused_addr_s = ^{s_axi_awaddr[31:ADDR_BITS], s_axi_araddr[31:ADDR_BITS]};

    // Bank strobes fire in the handshake cycle itself so writes land on that edge.
    assign wr_en   = s_axi_wvalid & wready_r;
    assign wr_addr = waddr_r;
    assign wr_data = s_axi_wdata;
    assign wr_mask = s_axi_wstrb;
    assign rd_en   = s_axi_arvalid & arready_r;
    assign rd_addr = s_axi_araddr[ADDR_BITS-1:0];

    assign s_axi_awready = awready_r;
    assign s_axi_wready  = wready_r;
    assign s_axi_bvalid  = bvalid_r;
    assign s_axi_bresp   = 2'b00;
    assign s_axi_arready = arready_r;
    assign s_axi_rvalid  = rvalid_r;
    assign s_axi_rdata   = rdata_r;
    assign s_axi_rresp   = 2'b00;

    // Write channel: AW, then W, then B.
    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn) begin
            wstate_r  <= WRIDLE;
            awready_r <= 1'b1;
            wready_r  <= 1'b0;
            bvalid_r  <= 1'b0;
            waddr_r   <= '0;
        end else begin
            case (wstate_r)
                WRIDLE: if (s_axi_awvalid) begin
                    waddr_r   <= s_axi_awaddr[ADDR_BITS-1:0];
                    awready_r <= 1'b0;
                    wready_r  <= 1'b1;
                    wstate_r  <= WRDATA;
                end
                WRDATA: if (s_axi_wvalid) begin
                    wready_r <= 1'b0;
                    bvalid_r <= 1'b1;
                    wstate_r <= WRRESP;
                end
                WRRESP: if (s_axi_bready) begin
                    bvalid_r  <= 1'b0;
                    awready_r <= 1'b1;
                    wstate_r  <= WRIDLE;
                end
                default: begin
                    wstate_r  <= WRIDLE;
                    awready_r <= 1'b1;
                    wready_r  <= 1'b0;
                    bvalid_r  <= 1'b0;
                end
            endcase
        end
    end

    // Read channel: data captured on the AR handshake, held until rready.
    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn) begin
            rstate_r  <= RDIDLE;
            arready_r <= 1'b1;
            rvalid_r  <= 1'b0;
            rdata_r   <= 32'd0;
        end else begin
            case (rstate_r)
                RDIDLE: if (s_axi_arvalid) begin
                    rdata_r   <= rd_data;
                    rvalid_r  <= 1'b1;
                    arready_r <= 1'b0;
                    rstate_r  <= RDDATA;
                end
                RDDATA: if (s_axi_rready) begin
                    rvalid_r  <= 1'b0;
                    arready_r <= 1'b1;
                    rstate_r  <= RDIDLE;
                end
                default: begin
                    rstate_r  <= RDIDLE;
                    arready_r <= 1'b1;
                    rvalid_r  <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: rtl/axi_lifirx_framebuf.sv
// Receive frame buffer: captures one AXI4-Stream frame, holds it until software ACKs.
// Optional interrupt output enabled by defining LIFIRX_FRAMEBUF_IRQ_EN.
module axi_lifirx_framebuf
    import lifirx_pkg::*;
#(
    parameter int C_DEPTH     = 8,
    parameter int C_ADDR_BITS = 9
) (
    input  logic        aclk,
    input  logic        aresetn,
    input  logic [31:0] s_axi_awaddr,
    input  logic        s_axi_awvalid,
    output logic        s_axi_awready,
    input  logic [31:0] s_axi_wdata,
    input  logic [3:0]  s_axi_wstrb,
    input  logic        s_axi_wvalid,
    output logic        s_axi_wready,
    output logic [1:0]  s_axi_bresp,
    output logic        s_axi_bvalid,
    input  logic        s_axi_bready,
    input  logic [31:0] s_axi_araddr,
    input  logic        s_axi_arvalid,
    output logic        s_axi_arready,
    output logic [31:0] s_axi_rdata,
    output logic [1:0]  s_axi_rresp,
    output logic        s_axi_rvalid,
    input  logic        s_axi_rready,
    output logic        s_axis_tready,
    input  logic [31:0] s_axis_tdata,
    input  logic        s_axis_tvalid,
    input  logic        s_axis_tlast,
    output logic [1:0]  demod_type,
    output logic [7:0]  fft_config,
`ifdef LIFIRX_FRAMEBUF_IRQ_EN
    output logic        fft_config_en,
    output logic        irq
`else
    output logic        fft_config_en
`endif
);

    localparam int IDX_W = $clog2(C_DEPTH);
    localparam int PTR_W = IDX_W + 1;
    localparam logic [C_ADDR_BITS-1:0] A_CTRL   = C_ADDR_BITS'(ADDR_CTRL);
    localparam logic [C_ADDR_BITS-1:0] A_STATUS = C_ADDR_BITS'(ADDR_STATUS);
    localparam logic [C_ADDR_BITS-1:0] A_FRMCNT = C_ADDR_BITS'(ADDR_FRMCNT);
    localparam logic [C_ADDR_BITS-1:0] A_ACK    = C_ADDR_BITS'(ADDR_ACK);
    localparam logic [C_ADDR_BITS-3:0] DATA_WORD   = (C_ADDR_BITS-2)'(ADDR_DATA_BASE >> 2);
    localparam logic [C_ADDR_BITS-3:0] DEPTH_WORDS = (C_ADDR_BITS-2)'(C_DEPTH);
    localparam logic [PTR_W-1:0]       DEPTH_PTR   = PTR_W'(C_DEPTH);

    logic                   wr_en_s;
    logic [C_ADDR_BITS-1:0] wr_addr_s;
    logic [31:0]            wr_data_s;
    logic [3:0]             wr_mask_s;
    logic                   rd_en_s;
    logic [C_ADDR_BITS-1:0] rd_addr_s;
    logic [31:0]            rd_data_s;

    strm_state_e            sstate_r;
    logic                   tready_r;
    logic [PTR_W-1:0]       wr_ptr_r;
    logic                   done_r;
    logic [7:0]             count_r;
    logic [15:0]            frmcnt_r;
    logic                   ovf_r;
    demod_e                 demod_r;
    logic                   irq_en_r;
    logic [31:0]            mem_r [C_DEPTH];

    logic                   beat_s;
    logic                   full_s;
    logic [PTR_W-1:0]       ptr_inc_s;
    logic                   ack_s;
    logic                   ovf_clr_s;
    logic [C_ADDR_BITS-3:0] rd_word_s;
    logic [C_ADDR_BITS-3:0] rd_off_s;
    logic                   data_hit_s;
    logic                   unused_s;

    lifirx_axil_slave #(.ADDR_BITS(C_ADDR_BITS)) u_axil (
        .aclk          (aclk),
        .aresetn       (aresetn),
        .s_axi_awaddr  (s_axi_awaddr),
        .s_axi_awvalid (s_axi_awvalid),
        .s_axi_awready (s_axi_awready),
        .s_axi_wdata   (s_axi_wdata),
        .s_axi_wstrb   (s_axi_wstrb),
        .s_axi_wvalid  (s_axi_wvalid),
        .s_axi_wready  (s_axi_wready),
        .s_axi_bresp   (s_axi_bresp),
        .s_axi_bvalid  (s_axi_bvalid),
        .s_axi_bready  (s_axi_bready),
        .s_axi_araddr  (s_axi_araddr),
        .s_axi_arvalid (s_axi_arvalid),
        .s_axi_arready (s_axi_arready),
        .s_axi_rdata   (s_axi_rdata),
        .s_axi_rresp   (s_axi_rresp),
        .s_axi_rvalid  (s_axi_rvalid),
        .s_axi_rready  (s_axi_rready),
        .wr_en         (wr_en_s),
        .wr_addr       (wr_addr_s),
        .wr_data       (wr_data_s),
        .wr_mask       (wr_mask_s),
        .rd_en         (rd_en_s),
        .rd_addr       (rd_addr_s),
        .rd_data       (rd_data_s)
    );

    assign unused_s      = ^{wr_data_s, wr_mask_s, rd_en_s};
    assign s_axis_tready = tready_r;
    assign demod_type    = demod_r;
    assign fft_config    = FFT_CONFIG;
    assign fft_config_en = 1'b1;

    assign beat_s    = s_axis_tvalid & tready_r;
    assign full_s    = (wr_ptr_r == DEPTH_PTR);
    assign ptr_inc_s = full_s ? wr_ptr_r : wr_ptr_r + PTR_W'(1);
    assign ack_s     = wr_en_s & (wr_addr_s == A_ACK) & wr_mask_s[0] & wr_data_s[0] & done_r;
    assign ovf_clr_s = wr_en_s & (wr_addr_s == A_STATUS) & wr_mask_s[1] & wr_data_s[8];

    // Stream capture FSM; beats past C_DEPTH are accepted but dropped.
    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn) begin
            sstate_r <= S_IDLE;
            tready_r <= 1'b1;
            wr_ptr_r <= '0;
            done_r   <= 1'b0;
            count_r  <= 8'd0;
            frmcnt_r <= 16'd0;
            for (int i = 0; i < C_DEPTH; i++) begin
                mem_r[i] <= 32'd0;
            end
        end else begin
            case (sstate_r)
                S_IDLE, S_CAPTURE: if (beat_s) begin
                    if (!full_s) begin
                        mem_r[wr_ptr_r[IDX_W-1:0]] <= s_axis_tdata;
                    end
                    wr_ptr_r <= ptr_inc_s;
                    if (s_axis_tlast) begin
                        sstate_r <= S_DONE;
                        tready_r <= 1'b0;
                        done_r   <= 1'b1;
                        count_r  <= 8'(ptr_inc_s);
                        frmcnt_r <= frmcnt_r + 16'd1;
                    end else begin
                        sstate_r <= S_CAPTURE;
                    end
                end
                S_DONE: if (ack_s) begin
                    sstate_r <= S_IDLE;
                    tready_r <= 1'b1;
                    done_r   <= 1'b0;
                    wr_ptr_r <= '0;
                end
                default: begin
                    sstate_r <= S_IDLE;
                    tready_r <= 1'b1;
                    done_r   <= 1'b0;
                    wr_ptr_r <= '0;
                end
            endcase
        end
    end

    // Sticky overflow; a new overflow beats a same-cycle clear.
    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn) begin
            ovf_r <= 1'b0;
        end else if (beat_s && full_s) begin
            ovf_r <= 1'b1;
        end else if (ovf_clr_s) begin
            ovf_r <= 1'b0;
        end
    end

    // CTRL register: byte 0 carries demod_type and irq_en.
    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn) begin
            demod_r  <= DEMOD_BPSK;
            irq_en_r <= 1'b0;
        end else if (wr_en_s && (wr_addr_s == A_CTRL) && wr_mask_s[0]) begin
            demod_r  <= demod_e'(wr_data_s[1:0]);
`ifdef LIFIRX_FRAMEBUF_IRQ_EN
            irq_en_r <= wr_data_s[3];
`else
            irq_en_r <= 1'b0;
`endif
        end
    end

`ifdef LIFIRX_FRAMEBUF_IRQ_EN
    logic irq_r;
    assign irq = irq_r;

    // Interrupt follows done one cycle later.
    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn) begin
            irq_r <= 1'b0;
        end else begin
            irq_r <= done_r & irq_en_r;
        end
    end
`endif

    assign rd_word_s  = rd_addr_s[C_ADDR_BITS-1:2];
    assign rd_off_s   = rd_word_s - DATA_WORD;
    assign data_hit_s = (rd_word_s >= DATA_WORD) && (rd_off_s < DEPTH_WORDS);

    // Register read mux.
    always_comb begin
        rd_data_s = 32'd0;
        case (rd_addr_s)
            A_CTRL:   rd_data_s = {28'd0, irq_en_r, done_r, demod_r};
            A_STATUS: rd_data_s = {23'd0, ovf_r, count_r};
            A_FRMCNT: rd_data_s = {16'd0, frmcnt_r};
            default: begin
                if (data_hit_s) begin
                    rd_data_s = mem_r[rd_off_s[IDX_W-1:0]];
                end else begin
                    rd_data_s = 32'd0;
                end
            end
        endcase
    end

endmodule

// File: tb/tb_axi_lifirx_framebuf.sv
// Self-checking bench for axi_lifirx_framebuf: directed steps plus random frames
// checked against a behavioural frame model.
module tb_axi_lifirx_framebuf;

    localparam int DEPTH = 8;

    logic        aclk = 1'b0;
    logic        aresetn = 1'b0;
    logic [31:0] awaddr = 32'd0, wdata = 32'd0, araddr = 32'd0, rdata, tdata = 32'd0;
    logic [3:0]  wstrb = 4'd0;
    logic        awvalid = 1'b0, wvalid = 1'b0, bready = 1'b0, arvalid = 1'b0, rready = 1'b0;
    logic        awready, wready, bvalid, arready, rvalid, tready;
    logic        tvalid = 1'b0, tlast = 1'b0;
    logic [1:0]  bresp, rresp, demod_type;
    logic [7:0]  fft_config;
    logic        fft_config_en;
`ifdef LIFIRX_FRAMEBUF_IRQ_EN
    logic        irq;
`endif

    int checks = 0;
    int errors = 0;

    logic [31:0] exp_mem [DEPTH];
    int          exp_frm;
    logic        exp_ovf;
    int          exp_cnt;
    logic [1:0]  exp_demod;

    always #5 aclk = ~aclk;

    axi_lifirx_framebuf #(.C_DEPTH(DEPTH), .C_ADDR_BITS(9)) dut (
        .aclk(aclk), .aresetn(aresetn),
        .s_axi_awaddr(awaddr), .s_axi_awvalid(awvalid), .s_axi_awready(awready),
        .s_axi_wdata(wdata), .s_axi_wstrb(wstrb), .s_axi_wvalid(wvalid), .s_axi_wready(wready),
        .s_axi_bresp(bresp), .s_axi_bvalid(bvalid), .s_axi_bready(bready),
        .s_axi_araddr(araddr), .s_axi_arvalid(arvalid), .s_axi_arready(arready),
        .s_axi_rdata(rdata), .s_axi_rresp(rresp), .s_axi_rvalid(rvalid), .s_axi_rready(rready),
        .s_axis_tready(tready), .s_axis_tdata(tdata), .s_axis_tvalid(tvalid), .s_axis_tlast(tlast),
        .demod_type(demod_type), .fft_config(fft_config),
`ifdef LIFIRX_FRAMEBUF_IRQ_EN
        .fft_config_en(fft_config_en), .irq(irq)
`else
        .fft_config_en(fft_config_en)
`endif
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed 0x%08h expected 0x%08h", tag, obs, exp);
        end
    endtask

    task automatic do_reset();
        aresetn = 1'b0;
        repeat (3) @(posedge aclk);
        #1 aresetn = 1'b1;
        @(posedge aclk);
        #1;
        for (int i = 0; i < DEPTH; i++) exp_mem[i] = 32'd0;
        exp_frm = 0; exp_ovf = 1'b0; exp_cnt = 0; exp_demod = 2'd0;
    endtask

    task automatic axi_write(input logic [31:0] a, input logic [31:0] d, input logic [3:0] s);
        bit bdone = 1'b0;
        int n = 0;
        awaddr = a; wdata = d; wstrb = s; awvalid = 1'b1; wvalid = 1'b1; bready = 1'b1;
        while ((awvalid || wvalid || !bdone) && n < 30) begin
            bit aw_hs, w_hs, b_hs;
            @(negedge aclk);
            aw_hs = awvalid && awready; w_hs = wvalid && wready; b_hs = bvalid && bready;
            @(posedge aclk);
            #1;
            if (aw_hs) awvalid = 1'b0;
            if (w_hs) wvalid = 1'b0;
            if (b_hs) begin bdone = 1'b1; bready = 1'b0; end
            n++;
        end
        awvalid = 1'b0; wvalid = 1'b0; bready = 1'b0;
        check("axi_write_done", {31'd0, bdone}, 32'd1);
    endtask

    task automatic axi_read(input logic [31:0] a, output logic [31:0] d);
        bit got = 1'b0;
        int n = 0;
        d = 32'hDEAD_BEEF;
        araddr = a; arvalid = 1'b1; rready = 1'b1;
        while (!got && n < 30) begin
            bit ar_hs, r_hs;
            @(negedge aclk);
            ar_hs = arvalid && arready; r_hs = rvalid && rready;
            if (r_hs) d = rdata;
            @(posedge aclk);
            #1;
            if (ar_hs) arvalid = 1'b0;
            if (r_hs) begin got = 1'b1; rready = 1'b0; end
            n++;
        end
        arvalid = 1'b0; rready = 1'b0;
        check("axi_read_done", {31'd0, got}, 32'd1);
    endtask

    task automatic chk_rd(input string tag, input logic [31:0] a, input logic [31:0] exp);
        logic [31:0] v;
        axi_read(a, v);
        check(tag, v, exp);
    endtask

    task automatic send_beat(input logic [31:0] d, input logic last);
        bit hs = 1'b0;
        int n = 0;
        tdata = d; tlast = last; tvalid = 1'b1;
        while (!hs && n < 50) begin
            @(negedge aclk);
            hs = tvalid && tready;
            @(posedge aclk);
            #1;
            n++;
        end
        tvalid = 1'b0; tlast = 1'b0;
        check("beat_accepted", {31'd0, hs}, 32'd1);
    endtask

    task automatic check_model(input logic done);
        chk_rd("m_ctrl", 32'h0, {29'd0, done, exp_demod});
        chk_rd("m_status", 32'h4, {23'd0, exp_ovf, 8'(exp_cnt)});
        chk_rd("m_frmcnt", 32'h8, {16'd0, 16'(exp_frm)});
        for (int i = 0; i < DEPTH; i++) chk_rd("m_data", 32'h100 + 32'(4 * i), exp_mem[i]);
    endtask

    initial begin
        do_reset();
        check("rst_tready", {31'd0, tready}, 32'd1);
        check("fft_cfg", {23'd0, fft_config_en, fft_config}, 32'h0000_0101);
        chk_rd("rst_ctrl", 32'h0, 32'h0);
        chk_rd("rst_status", 32'h4, 32'h0);
        chk_rd("rst_frmcnt", 32'h8, 32'h0);

        for (int i = 0; i < 4; i++) send_beat(32'hA0 + 32'(i), i == 3);
        check("done_tready", {31'd0, tready}, 32'd0);
        chk_rd("f1_ctrl", 32'h0, 32'h4);
        chk_rd("f1_status", 32'h4, 32'h004);
        chk_rd("f1_frmcnt", 32'h8, 32'h1);
        for (int i = 0; i < 4; i++) chk_rd("f1_data", 32'h100 + 32'(4 * i), 32'hA0 + 32'(i));
        chk_rd("unmapped_reg", 32'h10, 32'h0);
        chk_rd("unmapped_data", 32'h120, 32'h0);

        do_reset();
        for (int i = 0; i < 10; i++) send_beat(32'hB0 + 32'(i), i == 9);
        chk_rd("ovf_status", 32'h4, 32'h108);
        chk_rd("ovf_frmcnt", 32'h8, 32'h1);
        chk_rd("ovf_word0", 32'h100, 32'hB0);
        chk_rd("ovf_word7", 32'h11C, 32'hB7);
        axi_write(32'h4, 32'h100, 4'hF);
        chk_rd("ovf_clear", 32'h4, 32'h008);

        axi_write(32'hC, 32'h0, 4'hF);
        chk_rd("ack0_ctrl", 32'h0, 32'h4);
        check("ack0_tready", {31'd0, tready}, 32'd0);
        axi_write(32'hC, 32'h1, 4'hF);
        check("ack1_tready", {31'd0, tready}, 32'd1);
        chk_rd("ack1_ctrl", 32'h0, 32'h0);
        send_beat(32'hC0, 1'b1);
        chk_rd("f3_status", 32'h4, 32'h001);
        chk_rd("f3_frmcnt", 32'h8, 32'h2);
        chk_rd("f3_word0", 32'h100, 32'hC0);
        chk_rd("f3_stale1", 32'h104, 32'hB1);
        axi_write(32'hC, 32'h1, 4'h1);

        axi_write(32'h0, 32'h2, 4'h0);
        chk_rd("strb0_ctrl", 32'h0, 32'h0);
        axi_write(32'h0, 32'h2, 4'h1);
        chk_rd("strb1_ctrl", 32'h0, 32'h2);
        check("demod_port", {30'd0, demod_type}, 32'd2);

        fork
            axi_write(32'h0, 32'h1, 4'h1);
            chk_rd("conc_frmcnt", 32'h8, 32'h2);
        join
        chk_rd("conc_ctrl", 32'h0, 32'h1);

`ifdef LIFIRX_FRAMEBUF_IRQ_EN
        axi_write(32'h0, 32'h9, 4'h1);
        send_beat(32'hD0, 1'b1);
        check("irq_lag", {31'd0, irq}, 32'd0);
        @(posedge aclk);
        #1;
        check("irq_set", {31'd0, irq}, 32'd1);
        chk_rd("irq_ctrl", 32'h0, 32'hD);
        axi_write(32'hC, 32'h1, 4'h1);
        check("irq_clr", {31'd0, irq}, 32'd0);
`else
        axi_write(32'h0, 32'h9, 4'h1);
        chk_rd("noirq_ctrl", 32'h0, 32'h1);
`endif

        do_reset();
        for (int f = 0; f < 8; f++) begin
            int len;
            logic [1:0] dm;
            dm = 2'($urandom_range(0, 2));
            axi_write(32'h0, {30'd0, dm}, 4'h1);
            exp_demod = dm;
            len = $urandom_range(1, 12);
            for (int j = 0; j < len; j++) begin
                logic [31:0] d;
                d = $urandom;
                send_beat(d, j == len - 1);
                if (j < DEPTH) exp_mem[j] = d;
            end
            exp_cnt = (len > DEPTH) ? DEPTH : len;
            if (len > DEPTH) exp_ovf = 1'b1;
            exp_frm++;
            check("rnd_tready_done", {31'd0, tready}, 32'd0);
            check_model(1'b1);
            if ($urandom_range(0, 1) == 1) begin
                axi_write(32'h4, 32'h100, 4'hF);
                exp_ovf = 1'b0;
            end
            axi_write(32'hC, 32'h1, 4'h1);
            check("rnd_tready_idle", {31'd0, tready}, 32'd1);
            chk_rd("rnd_status", 32'h4, {23'd0, exp_ovf, 8'(exp_cnt)});
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
